// File: rtl/nv_nvdla_mcif_read_wrr_os.sv
// WRR read-request arbiter with outstanding-credit limit; 1-cycle registered output, clients stall while credits are exhausted or the output register is held by arb_out_ready=0.
// Optional NVDLA_MCIF_RD_OS_STALL_CNT_EN adds a saturating os_stall_cnt of credit-starved cycles.
module nv_nvdla_mcif_read_wrr_os #(
    parameter int NUM_CLT  = 8,
    parameter int PD_W     = 79,
    parameter int CLT_ID_W = 4
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    input  logic [NUM_CLT-1:0]      clt_req_valid,
    output logic [NUM_CLT-1:0]      clt_req_ready,
    input  logic [NUM_CLT*PD_W-1:0] clt_req_pd,
    input  logic [NUM_CLT*8-1:0]    reg2dp_rd_weight,
    input  logic [7:0]              reg2dp_rd_os_cnt,
    output logic                    arb_out_valid,
    input  logic                    arb_out_ready,
    output logic [PD_W-1:0]         arb_out_pd,
    output logic [CLT_ID_W-1:0]     arb_out_clt_id,
    input  logic                    eg2ig_axi_vld,
`ifdef NVDLA_MCIF_RD_OS_STALL_CNT_EN
    output logic [31:0]             os_stall_cnt,
`endif
    output logic [8:0]              os_inflight
);

    logic                r_out_vld;
    logic [PD_W-1:0]     r_out_pd;
    logic [CLT_ID_W-1:0] r_out_id;
    logic [CLT_ID_W-1:0] r_gnt;
    logic [7:0]          r_burst;
    logic [8:0]          r_os;

    logic [8:0]          w_limit;
    logic                w_credit_ok;
    logic                w_accept_en;
    logic                w_any_vld;
    logic                w_hold_vld;
    logic [7:0]          w_quota;
    logic                w_hold;
    logic [CLT_ID_W-1:0] w_nxt;
    logic [CLT_ID_W-1:0] w_gnt;
    logic                w_hs;
    logic [PD_W-1:0]     w_pd_sel;
    logic                w_dec;

    assign w_limit     = {1'b0, reg2dp_rd_os_cnt} + 9'd1;
    assign w_credit_ok = (r_os < w_limit);
    assign w_accept_en = w_credit_ok && (!r_out_vld || arb_out_ready);
    assign w_any_vld   = |clt_req_valid;
    assign w_hs        = w_any_vld && w_accept_en;
    assign w_dec       = eg2ig_axi_vld && (r_os != 9'd0);

    // Holder keeps the grant while valid and under quota; otherwise the nearest
    // valid client after it (wrapping, the holder itself last) takes over.
    always_comb begin
        int d;
        int best;
        w_hold_vld = 1'b0;
        w_quota    = 8'd1;
        w_nxt      = r_gnt;
        best       = NUM_CLT + 1;
        d          = 0;
        for (int i = 0; i < NUM_CLT; i++) begin
            if (r_gnt == CLT_ID_W'(i)) begin
                w_hold_vld = clt_req_valid[i];
                w_quota    = (reg2dp_rd_weight[i*8 +: 8] == 8'd0) ? 8'd1 : reg2dp_rd_weight[i*8 +: 8];
            end
            if (clt_req_valid[i]) begin
                d = (i + NUM_CLT - int'(r_gnt)) % NUM_CLT;
                if (d == 0) d = NUM_CLT;
                if (d < best) begin
                    best  = d;
                    w_nxt = CLT_ID_W'(i);
                end
            end
        end
        w_hold = w_hold_vld && (r_burst < w_quota);
        w_gnt  = w_hold ? r_gnt : w_nxt;
    end

    always_comb begin
        clt_req_ready = '0;
        w_pd_sel      = '0;
        for (int i = 0; i < NUM_CLT; i++) begin
            if (w_gnt == CLT_ID_W'(i)) begin
                clt_req_ready[i] = w_hs;
                w_pd_sel         = clt_req_pd[i*PD_W +: PD_W];
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_gnt   <= '0;
            r_burst <= 8'd0;
        end else if (w_hs) begin
            if (w_hold) begin
                r_burst <= r_burst + 8'd1;
            end else begin
                r_gnt   <= w_gnt;
                r_burst <= 8'd1;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_out_vld <= 1'b0;
            r_out_pd  <= '0;
            r_out_id  <= '0;
        end else if (w_hs) begin
            r_out_vld <= 1'b1;
            r_out_pd  <= w_pd_sel;
            r_out_id  <= w_gnt;
        end else if (arb_out_ready) begin
            r_out_vld <= 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_os <= 9'd0;
        end else begin
            case ({w_hs, w_dec})
                2'b10:   if (r_os != 9'd511) r_os <= r_os + 9'd1;
                2'b01:   r_os <= r_os - 9'd1;
                default: r_os <= r_os;
            endcase
        end
    end

`ifdef NVDLA_MCIF_RD_OS_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_stall_cnt <= 32'd0;
        end else if (w_any_vld && !w_credit_ok && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
    assign os_stall_cnt = r_stall_cnt;
`endif

    assign arb_out_valid  = r_out_vld;
    assign arb_out_pd     = r_out_pd;
    assign arb_out_clt_id = r_out_id;
    assign os_inflight    = r_os;

endmodule

// File: tb/tb_nv_nvdla_mcif_read_wrr_os.sv
// Directed bench for the WRR outstanding-limited read arbiter.
module tb_nv_nvdla_mcif_read_wrr_os;
    localparam int NUM_CLT  = 8;
    localparam int PD_W     = 79;
    localparam int CLT_ID_W = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CLT-1:0]      clt_req_valid;
    logic [NUM_CLT-1:0]      clt_req_ready;
    logic [NUM_CLT*PD_W-1:0] clt_req_pd;
    logic [NUM_CLT*8-1:0]    reg2dp_rd_weight;
    logic [7:0]              reg2dp_rd_os_cnt;
    logic                    arb_out_valid;
    logic                    arb_out_ready;
    logic [PD_W-1:0]         arb_out_pd;
    logic [CLT_ID_W-1:0]     arb_out_clt_id;
    logic                    eg2ig_axi_vld;
    logic [8:0]              os_inflight;
`ifdef NVDLA_MCIF_RD_OS_STALL_CNT_EN
    logic [31:0]             os_stall_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nv_nvdla_mcif_read_wrr_os #(
        .NUM_CLT(NUM_CLT), .PD_W(PD_W), .CLT_ID_W(CLT_ID_W)
    ) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rst_n),
        .clt_req_valid    (clt_req_valid),
        .clt_req_ready    (clt_req_ready),
        .clt_req_pd       (clt_req_pd),
        .reg2dp_rd_weight (reg2dp_rd_weight),
        .reg2dp_rd_os_cnt (reg2dp_rd_os_cnt),
        .arb_out_valid    (arb_out_valid),
        .arb_out_ready    (arb_out_ready),
        .arb_out_pd       (arb_out_pd),
        .arb_out_clt_id   (arb_out_clt_id),
        .eg2ig_axi_vld    (eg2ig_axi_vld),
`ifdef NVDLA_MCIF_RD_OS_STALL_CNT_EN
        .os_stall_cnt     (os_stall_cnt),
`endif
        .os_inflight      (os_inflight)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n            = 1'b0;
        clt_req_valid    = '0;
        clt_req_pd       = '0;
        reg2dp_rd_weight = {NUM_CLT{8'd1}};
        reg2dp_rd_os_cnt = 8'd255;
        arb_out_ready    = 1'b1;
        eg2ig_axi_vld    = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [PD_W-1:0] pa;
        pa = 79'h5A5A_1234_5678_9ABC_DEF0;
        do_reset();
        n_vec++; if (arb_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", arb_out_valid); end
        n_vec++; if (os_inflight !== 9'd0) begin n_bad++; $display("FAIL rst_inflight: got %0d want 0", os_inflight); end
        n_vec++; if (arb_out_clt_id !== 4'd0) begin n_bad++; $display("FAIL rst_id: got %0d want 0", arb_out_clt_id); end
        n_vec++; if (arb_out_pd !== '0) begin n_bad++; $display("FAIL rst_pd: got %h want 0", arb_out_pd); end
        // load the output register, then reset mid-cycle
        arb_out_ready = 1'b0;
        clt_req_valid = 8'b0010_0000;
        clt_req_pd[5*PD_W +: PD_W] = pa;
        tick();
        clt_req_valid = '0;
        n_vec++; if (arb_out_clt_id !== 4'd5) begin n_bad++; $display("FAIL pre_rst_id: got %0d want 5", arb_out_clt_id); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (arb_out_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid: got %b want 0", arb_out_valid); end
        n_vec++; if (os_inflight !== 9'd0) begin n_bad++; $display("FAIL async_rst_inflight: got %0d want 0", os_inflight); end
        n_vec++; if (arb_out_pd !== '0 || arb_out_clt_id !== 4'd0) begin n_bad++; $display("FAIL async_rst_pd_id: got %h/%0d want 0/0", arb_out_pd, arb_out_clt_id); end
    endtask

    task automatic test_first_grant;
        logic [PD_W-1:0] pa;
        pa = 79'h0C0F_FEE0_0000_0000_0003;
        do_reset();
        clt_req_valid = 8'b0000_1000;
        clt_req_pd[3*PD_W +: PD_W] = pa;
        #1;
        n_vec++; if (clt_req_ready !== 8'b0000_1000) begin n_bad++; $display("FAIL first_ready: got %b want 00001000", clt_req_ready); end
        tick();
        clt_req_valid = '0;
        n_vec++; if (arb_out_valid !== 1'b1 || arb_out_clt_id !== 4'd3) begin n_bad++; $display("FAIL first_out: got vld=%b id=%0d want vld=1 id=3", arb_out_valid, arb_out_clt_id); end
        n_vec++; if (arb_out_pd !== pa) begin n_bad++; $display("FAIL first_pd: got %h want %h", arb_out_pd, pa); end
        tick();
        n_vec++; if (arb_out_valid !== 1'b0) begin n_bad++; $display("FAIL first_drain: got %b want 0", arb_out_valid); end
    endtask

    task automatic test_wrr;
        int seq1[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
        int seq2[4] = '{0, 1, 0, 1};
        logic [7:0] exp_rdy;
        do_reset();
        reg2dp_rd_weight[0 +: 8] = 8'd2;
        reg2dp_rd_weight[8 +: 8] = 8'd1;
        eg2ig_axi_vld = 1'b1;
        clt_req_valid = 8'b0000_0011;
        for (int c = 0; c < 9; c++) begin
            exp_rdy = 8'b1 << seq1[c];
            #1;
            n_vec++; if (clt_req_ready !== exp_rdy) begin n_bad++; $display("FAIL wrr21_ready[%0d]: got %b want %b", c, clt_req_ready, exp_rdy); end
            tick();
            n_vec++; if (arb_out_clt_id !== 4'(seq1[c])) begin n_bad++; $display("FAIL wrr21_id[%0d]: got %0d want %0d", c, arb_out_clt_id, seq1[c]); end
        end
        do_reset();
        reg2dp_rd_weight = '0;
        eg2ig_axi_vld = 1'b1;
        clt_req_valid = 8'b0000_0011;
        for (int c = 0; c < 4; c++) begin
            exp_rdy = 8'b1 << seq2[c];
            #1;
            n_vec++; if (clt_req_ready !== exp_rdy) begin n_bad++; $display("FAIL wrr00_ready[%0d]: got %b want %b", c, clt_req_ready, exp_rdy); end
            tick();
        end
        clt_req_valid = '0;
        eg2ig_axi_vld = 1'b0;
    endtask

    task automatic test_credit;
        int acc;
        do_reset();
        reg2dp_rd_os_cnt = 8'd3;
        clt_req_valid = 8'b0000_0001;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (clt_req_ready != '0) acc++;
            tick();
        end
        n_vec++; if (acc !== 4) begin n_bad++; $display("FAIL credit_accepts: got %0d want 4", acc); end
        n_vec++; if (os_inflight !== 9'd4) begin n_bad++; $display("FAIL credit_inflight: got %0d want 4", os_inflight); end
        eg2ig_axi_vld = 1'b1;
        #1;
        n_vec++; if (clt_req_ready !== 8'b0) begin n_bad++; $display("FAIL credit_stall: got %b want 0", clt_req_ready); end
        tick();
        eg2ig_axi_vld = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (clt_req_ready != '0) acc++;
            tick();
        end
        n_vec++; if (acc !== 1) begin n_bad++; $display("FAIL credit_refill: got %0d want 1", acc); end
        clt_req_valid = '0;
    endtask

    task automatic test_back_to_back;
        logic [PD_W-1:0] pa;
        logic [PD_W-1:0] pb;
        pa = 79'h1111_2222_3333_4444_5555;
        pb = 79'h6666_7777_0000_8888_9999;
        do_reset();
        arb_out_ready = 1'b0;
        clt_req_valid = 8'b0000_0100;
        clt_req_pd[2*PD_W +: PD_W] = pa;
        #1;
        n_vec++; if (clt_req_ready !== 8'b0000_0100) begin n_bad++; $display("FAIL bp_first_ready: got %b want 00000100", clt_req_ready); end
        tick();
        clt_req_pd[2*PD_W +: PD_W] = pb;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_vec++; if (arb_out_valid !== 1'b1 || arb_out_pd !== pa || arb_out_clt_id !== 4'd2) begin n_bad++; $display("FAIL bp_hold[%0d]: got vld=%b pd=%h id=%0d want 1/%h/2", c, arb_out_valid, arb_out_pd, arb_out_clt_id, pa); end
            n_vec++; if (clt_req_ready !== 8'b0) begin n_bad++; $display("FAIL bp_blocked[%0d]: got %b want 0", c, clt_req_ready); end
            tick();
        end
        arb_out_ready = 1'b1;
        #1;
        n_vec++; if (clt_req_ready !== 8'b0000_0100) begin n_bad++; $display("FAIL b2b_ready: got %b want 00000100", clt_req_ready); end
        tick();
        clt_req_valid = '0;
        n_vec++; if (arb_out_valid !== 1'b1 || arb_out_pd !== pb) begin n_bad++; $display("FAIL b2b_pd: got vld=%b pd=%h want 1/%h", arb_out_valid, arb_out_pd, pb); end
        tick();
        n_vec++; if (arb_out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", arb_out_valid); end
    endtask

    task automatic test_os_count;
        do_reset();
        eg2ig_axi_vld = 1'b1;
        tick();
        n_vec++; if (os_inflight !== 9'd0) begin n_bad++; $display("FAIL os_underflow: got %0d want 0", os_inflight); end
        eg2ig_axi_vld = 1'b0;
        clt_req_valid = 8'b0000_0001;
        repeat (2) tick();
        n_vec++; if (os_inflight !== 9'd2) begin n_bad++; $display("FAIL os_two: got %0d want 2", os_inflight); end
        reg2dp_rd_os_cnt = 8'd1;
        #1;
        n_vec++; if (clt_req_ready !== 8'b0) begin n_bad++; $display("FAIL os_limit_drop: got %b want 0", clt_req_ready); end
        reg2dp_rd_os_cnt = 8'd255;
        eg2ig_axi_vld = 1'b1;
        #1;
        n_vec++; if (clt_req_ready !== 8'b0000_0001) begin n_bad++; $display("FAIL os_same_ready: got %b want 00000001", clt_req_ready); end
        tick();
        n_vec++; if (os_inflight !== 9'd2) begin n_bad++; $display("FAIL os_same_cycle: got %0d want 2", os_inflight); end
        clt_req_valid = '0;
        repeat (2) tick();
        n_vec++; if (os_inflight !== 9'd0) begin n_bad++; $display("FAIL os_drain: got %0d want 0", os_inflight); end
        tick();
        n_vec++; if (os_inflight !== 9'd0) begin n_bad++; $display("FAIL os_floor: got %0d want 0", os_inflight); end
        eg2ig_axi_vld = 1'b0;
    endtask

`ifdef NVDLA_MCIF_RD_OS_STALL_CNT_EN
    task automatic test_stall_cnt;
        do_reset();
        n_vec++; if (os_stall_cnt !== 32'd0) begin n_bad++; $display("FAIL stall_rst: got %0d want 0", os_stall_cnt); end
        reg2dp_rd_os_cnt = 8'd0;
        clt_req_valid = 8'b0000_0001;
        tick();
        repeat (10) tick();
        clt_req_valid = '0;
        tick();
        n_vec++; if (os_stall_cnt !== 32'd10) begin n_bad++; $display("FAIL stall_cnt: got %0d want 10", os_stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_grant();
        test_wrr();
        test_credit();
        test_back_to_back();
        test_os_count();
`ifdef NVDLA_MCIF_RD_OS_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
